// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: shared types and constants for the register-file/ALU pipeline.
// Opcode encoding, default geometry and status-flag bit positions.
package reg_alu_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    // Bit positions inside the two-bit status register
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_ADC    = 3'd5,
        OP_SBB    = 3'd6,
        OP_PASS_A = 3'd7
    } alu_op_e;

endpackage

// File: rtl/reg_alu_pipe_alu_core.sv
// alu_core: purely combinational ALU used in the execute stage.
// Arithmetic runs one bit wider than the data so the top bit is the carry;
// for SUB/SBB a carry of 1 means no borrow. Logic ops report carry = 0.
module alu_core
    import reg_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] sum_s;

    // Select the operation and form the widened result
    always_comb begin
        sum_s = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD:    sum_s = {1'b0, a} + {1'b0, b};
            OP_SUB:    sum_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            OP_AND:    sum_s = {1'b0, a & b};
            OP_OR:     sum_s = {1'b0, a | b};
            OP_XOR:    sum_s = {1'b0, a ^ b};
            OP_ADC:    sum_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            OP_SBB:    sum_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
            OP_PASS_A: sum_s = {1'b0, a};
            default:   sum_s = {(WIDTH+1){1'b0}};
        endcase
    end

    assign y     = sum_s[WIDTH-1:0];
    assign carry = sum_s[WIDTH];

endmodule

// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: register file with integrated ALU, two-stage pipeline
// (operand read, then execute/writeback) with carry/zero status register.
// Optional macro REG_ALU_FWD_EN: when defined, the operand read stage
// forwards the value being written back in the same cycle, so dependent
// back-to-back ops see the new value. When undefined, the read stage sees
// the pre-write contents and software inserts one idle cycle.
module reg_alu_pipe
    import reg_alu_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             sel,
    input  logic             wr,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             done
);

    logic [WIDTH-1:0] regs_r [DEPTH];

    // Execute-stage control register
    logic             s2_valid_r;
    logic             sel_s2_r;
    logic             wr_s2_r;
    alu_op_e          op_s2_r;
    logic [AW-1:0]    wr_addr_s2_r;
    logic [WIDTH-1:0] d_in_s2_r;
    logic [1:0]       flags_r;

    logic [WIDTH-1:0] alu_y_s;
    logic             alu_carry_s;
    logic [WIDTH-1:0] wb_y_s;
    logic [WIDTH-1:0] opnd_a_s;
    logic [WIDTH-1:0] opnd_b_s;

    assign cout = flags_r[FLAG_C];
    assign zero = flags_r[FLAG_Z];

    // Carry-in is the flag as it stands at the execute edge, so carry ops chain without a stall
    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a     (d_out_a),
        .b     (d_out_b),
        .cin   (flags_r[FLAG_C]),
        .op    (op_s2_r),
        .y     (alu_y_s),
        .carry (alu_carry_s)
    );

    // Writeback value: ALU result or the external load data
    always_comb begin
        if (sel_s2_r) begin
            wb_y_s = alu_y_s;
        end else begin
            wb_y_s = d_in_s2_r;
        end
    end

    // Operand read mux, optionally forwarding the in-flight writeback
    always_comb begin
        opnd_a_s = regs_r[rd_addr_a];
        opnd_b_s = regs_r[rd_addr_b];
`ifdef REG_ALU_FWD_EN
        if (s2_valid_r && wr_s2_r && (wr_addr_s2_r == rd_addr_a)) begin
            opnd_a_s = wb_y_s;
        end else begin
            opnd_a_s = regs_r[rd_addr_a];
        end
        if (s2_valid_r && wr_s2_r && (wr_addr_s2_r == rd_addr_b)) begin
            opnd_b_s = wb_y_s;
        end else begin
            opnd_b_s = regs_r[rd_addr_b];
        end
`endif
    end

    // Operand read stage: capture operands and execute-stage control on issue
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out_a      <= {WIDTH{1'b0}};
            d_out_b      <= {WIDTH{1'b0}};
            s2_valid_r   <= 1'b0;
            sel_s2_r     <= 1'b0;
            wr_s2_r      <= 1'b0;
            op_s2_r      <= OP_ADD;
            wr_addr_s2_r <= {AW{1'b0}};
            d_in_s2_r    <= {WIDTH{1'b0}};
        end else begin
            s2_valid_r <= valid;
            if (valid) begin
                d_out_a      <= opnd_a_s;
                d_out_b      <= opnd_b_s;
                sel_s2_r     <= sel;
                wr_s2_r      <= wr;
                op_s2_r      <= alu_op_e'(op);
                wr_addr_s2_r <= wr_addr;
                d_in_s2_r    <= d_in;
            end
        end
    end

    // Execute/writeback stage: result, flags, register write and retire pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            result  <= {WIDTH{1'b0}};
            flags_r <= 2'b00;
            done    <= 1'b0;
        end else begin
            done <= s2_valid_r;
            if (s2_valid_r) begin
                result <= wb_y_s;
                if (wr_s2_r) begin
                    regs_r[wr_addr_s2_r] <= wb_y_s;
                end
                if (sel_s2_r) begin
                    flags_r[FLAG_C] <= alu_carry_s;
                    flags_r[FLAG_Z] <= (wb_y_s == {WIDTH{1'b0}});
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb_reg_alu_pipe: directed-vector bench for reg_alu_pipe with hand-computed
// expectations. Build with or without REG_ALU_FWD_EN; the forwarding cases
// pick their expected values from the same macro.
module tb_reg_alu_pipe;
    import reg_alu_pkg::*;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          valid;
    logic          sel;
    logic          wr;
    logic [2:0]    op;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  d_in;
    logic [W-1:0]  d_out_a;
    logic [W-1:0]  d_out_b;
    logic [W-1:0]  result;
    logic          cout;
    logic          zero;
    logic          done;

    int checks;
    int errors;

    reg_alu_pipe #(.WIDTH(W), .DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .sel       (sel),
        .wr        (wr),
        .op        (op),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .done      (done)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op on the next edge, then drop valid
    task automatic do_op(input logic s, input logic w, input alu_op_e o,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] wa, input logic [W-1:0] d);
        valid     = 1'b1;
        sel       = s;
        wr        = w;
        op        = o;
        rd_addr_a = a;
        rd_addr_b = b;
        wr_addr   = wa;
        d_in      = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] wa, input logic [W-1:0] d);
        do_op(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, wa, d);
    endtask

    task automatic idle();
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Read a register through PASS_A without writing anything back
    task automatic read_reg(input string tag, input logic [AW-1:0] r, input logic [W-1:0] exp);
        do_op(1'b1, 1'b0, OP_PASS_A, r, 3'd0, 3'd0, 16'h0000);
        idle();
        check_eq(tag, result, exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        valid     = 1'b0;
        sel       = 1'b0;
        wr        = 1'b0;
        op        = 3'd0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_addr   = 3'd0;
        d_in      = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Arbitrary activity before a reset
        load(3'd1, 16'hffff);
        load(3'd2, 16'h0001);
        idle();
        do_op(1'b1, 1'b1, OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000);
        idle();
        check_eq("pre_add_c", {15'd0, cout}, 16'h0001);
        check_eq("pre_add_z", {15'd0, zero}, 16'h0001);
        load(3'd4, 16'h5a5a);
        idle();
        check_eq("load_res", result, 16'h5a5a);
        check_eq("load_keep_c", {15'd0, cout}, 16'h0001);
        check_eq("load_keep_z", {15'd0, zero}, 16'h0001);

        // Reset for two cycles with a load attempted during it
        reset = 1'b1;
        do_op(1'b0, 1'b1, OP_ADD, 3'd1, 3'd1, 3'd5, 16'hbeef);
        do_op(1'b0, 1'b1, OP_ADD, 3'd1, 3'd1, 3'd5, 16'hbeef);
        reset = 1'b0;
        check_eq("rst_result", result, 16'h0000);
        check_eq("rst_dout_a", d_out_a, 16'h0000);
        check_eq("rst_dout_b", d_out_b, 16'h0000);
        check_eq("rst_cout", {15'd0, cout}, 16'h0000);
        check_eq("rst_zero", {15'd0, zero}, 16'h0000);
        check_eq("rst_done", {15'd0, done}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            read_reg($sformatf("rst_r%0d", i), i[AW-1:0], 16'h0000);
        end

        // Loads then ADD
        load(3'd3, 16'hcdef);
        load(3'd7, 16'h3210);
        idle();
        do_op(1'b1, 1'b1, OP_ADD, 3'd3, 3'd7, 3'd5, 16'h0000);
        check_eq("add_done_early", {15'd0, done}, 16'h0000);
        check_eq("add_dout_a", d_out_a, 16'hcdef);
        check_eq("add_dout_b", d_out_b, 16'h3210);
        idle();
        check_eq("add_res", result, 16'hffff);
        check_eq("add_c", {15'd0, cout}, 16'h0000);
        check_eq("add_z", {15'd0, zero}, 16'h0000);
        check_eq("add_done", {15'd0, done}, 16'h0001);
        idle();
        check_eq("add_done_drop", {15'd0, done}, 16'h0000);
        read_reg("add_r5", 3'd5, 16'hffff);

        // Carry chain: ADD producing carry, then ADC of zeros
        load(3'd2, 16'hffff);
        load(3'd4, 16'h0001);
        idle();
        do_op(1'b1, 1'b1, OP_ADD, 3'd2, 3'd4, 3'd2, 16'h0000);
        do_op(1'b1, 1'b0, OP_ADC, 3'd0, 3'd0, 3'd6, 16'h0000);
        check_eq("cc_add_res", result, 16'h0000);
        check_eq("cc_add_c", {15'd0, cout}, 16'h0001);
        check_eq("cc_add_z", {15'd0, zero}, 16'h0001);
        idle();
        check_eq("cc_adc_res", result, 16'h0001);
        check_eq("cc_adc_c", {15'd0, cout}, 16'h0000);
        check_eq("cc_adc_z", {15'd0, zero}, 16'h0000);

        // SUB then SBB with borrow propagation
        load(3'd1, 16'h0005);
        load(3'd4, 16'h0007);
        idle();
        do_op(1'b1, 1'b0, OP_SUB, 3'd1, 3'd4, 3'd0, 16'h0000);
        do_op(1'b1, 1'b0, OP_SBB, 3'd4, 3'd1, 3'd0, 16'h0000);
        check_eq("sub_res", result, 16'hfffe);
        check_eq("sub_c", {15'd0, cout}, 16'h0000);
        idle();
        check_eq("sbb_res", result, 16'h0001);
        check_eq("sbb_c", {15'd0, cout}, 16'h0001);

        // Logic ops clear carry
        do_op(1'b1, 1'b0, OP_OR, 3'd1, 3'd4, 3'd0, 16'h0000);
        idle();
        check_eq("or_res", result, 16'h0007);
        check_eq("or_c", {15'd0, cout}, 16'h0000);
        do_op(1'b1, 1'b0, OP_AND, 3'd1, 3'd4, 3'd0, 16'h0000);
        idle();
        check_eq("and_res", result, 16'h0005);

        // wr=0 still retires but leaves the register alone
        do_op(1'b1, 1'b0, OP_ADD, 3'd1, 3'd1, 3'd4, 16'h0000);
        idle();
        check_eq("nowr_res", result, 16'h000a);
        check_eq("nowr_done", {15'd0, done}, 16'h0001);
        read_reg("nowr_r4", 3'd4, 16'h0007);

        // Forwarding: ADD->r5 (old r5 = ffff) immediately followed by XOR r5,r5
        do_op(1'b1, 1'b1, OP_ADD, 3'd1, 3'd4, 3'd5, 16'h0000);
        do_op(1'b1, 1'b0, OP_XOR, 3'd5, 3'd5, 3'd0, 16'h0000);
        check_eq("fwd_add_res", result, 16'h000c);
`ifdef REG_ALU_FWD_EN
        check_eq("fwd_xor_opa", d_out_a, 16'h000c);
`else
        check_eq("fwd_xor_opa", d_out_a, 16'hffff);
`endif
        idle();
        check_eq("fwd_xor_res", result, 16'h0000);
        check_eq("fwd_xor_z", {15'd0, zero}, 16'h0001);
        do_op(1'b1, 1'b1, OP_ADD, 3'd4, 3'd4, 3'd5, 16'h0000);
        do_op(1'b1, 1'b0, OP_PASS_A, 3'd5, 3'd0, 3'd0, 16'h0000);
        idle();
`ifdef REG_ALU_FWD_EN
        check_eq("fwd_pass", result, 16'h000e);
`else
        check_eq("fwd_pass", result, 16'h000c);
`endif
        read_reg("fwd_r5_late", 3'd5, 16'h000e);

        // Reset mid-op discards the in-flight write and its done pulse
        load(3'd6, 16'h1234);
        idle();
        read_reg("mid_r6_pre", 3'd6, 16'h1234);
        do_op(1'b1, 1'b1, OP_ADD, 3'd1, 3'd4, 3'd6, 16'h0000);
        reset = 1'b1;
        idle();
        check_eq("mid_done_rst", {15'd0, done}, 16'h0000);
        check_eq("mid_res_rst", result, 16'h0000);
        reset = 1'b0;
        idle();
        check_eq("mid_done_after", {15'd0, done}, 16'h0000);
        read_reg("mid_r6_post", 3'd6, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
